packet_injector: RTL



---
 rtl/packet_injector_if.sv | 40 ++++
 rtl/packet_injector.sv | 139 +++++++++++++
 2 files changed

// File: rtl/packet_injector_if.sv
//------------------------------------------------------------------------------
// Module      : packet_injector_if
// Description : Request, payload and router-side flit bundle for packet_injector.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

interface packet_injector_if #(
    parameter int TAM_FLIT = 16
);
    logic                i_req_valid;
    logic                o_req_ready;
    logic [1:0]          i_dest_x;
    logic [1:0]          i_dest_y;
    logic [7:0]          i_len;
    logic                i_data_valid;
    logic                o_data_ready;
    logic [TAM_FLIT-1:0] i_data;
    logic                o_tx;
    logic [TAM_FLIT-1:0] o_data_out;
    logic                i_credit;
    logic                o_busy;
    logic                o_pkt_sent;

    // master: request/payload source and router credit side
    modport master (
        output i_req_valid, i_dest_x, i_dest_y, i_len,
        output i_data_valid, i_data, i_credit,
        input  o_req_ready, o_data_ready, o_tx, o_data_out, o_busy, o_pkt_sent
    );

    // slave: the injector itself
    modport slave (
        input  i_req_valid, i_dest_x, i_dest_y, i_len,
        input  i_data_valid, i_data, i_credit,
        output o_req_ready, o_data_ready, o_tx, o_data_out, o_busy, o_pkt_sent
    );
endinterface

`default_nettype wire

// File: rtl/packet_injector.sv
//------------------------------------------------------------------------------
// Module      : packet_injector
// Description : Local-port transmitter: header, size and payload flits under
//               credit-based flow control.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module packet_injector #(
    parameter logic [15:0] ADDRESS  = 16'h0000,
    parameter int          TAM_FLIT = 16
) (
    input  wire logic        i_clk,
    input  wire logic        i_rst,
    packet_injector_if.slave bus
);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_HEADER  = 3'd1,
        S_SIZE    = 3'd2,
        S_PAYLOAD = 3'd3,
        S_DONE    = 3'd4
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic                r_tx;
    logic                w_tx_nxt;
    logic [TAM_FLIT-1:0] r_data_out;
    logic [TAM_FLIT-1:0] w_data_out_nxt;
    logic [7:0]          r_len;
    logic [7:0]          w_len_nxt;
    logic [7:0]          r_remaining;
    logic [7:0]          w_remaining_nxt;
    logic [7:0]          r_loaded;
    logic [7:0]          w_loaded_nxt;

    logic                w_xfer;
    logic                w_data_ready;
    logic [TAM_FLIT-1:0] w_header;
    logic [TAM_FLIT-1:0] w_size_flit;

    assign w_xfer = r_tx & bus.i_credit;

    // A new word may be loaded while the register is empty or draining this edge.
    assign w_data_ready = (r_state == S_PAYLOAD) && bus.i_data_valid &&
                          (!r_tx || bus.i_credit) && (r_loaded < r_len);

    always_comb begin
        w_header        = '0;
        w_header[15:8]  = {bus.i_dest_x, bus.i_dest_y, ADDRESS[9:8], ADDRESS[1:0]};
        w_size_flit     = '0;
        w_size_flit[7:0] = r_len;
    end

    always_comb begin
        w_state_nxt     = r_state;
        w_tx_nxt        = r_tx;
        w_data_out_nxt  = r_data_out;
        w_len_nxt       = r_len;
        w_remaining_nxt = r_remaining;
        w_loaded_nxt    = r_loaded;
        case (r_state)
            S_IDLE: begin
                if (bus.i_req_valid) begin
                    w_len_nxt      = bus.i_len;
                    w_data_out_nxt = w_header;
                    w_tx_nxt       = 1'b1;
                    w_state_nxt    = S_HEADER;
                end
            end
            S_HEADER: begin
                if (w_xfer) begin
                    w_data_out_nxt = w_size_flit;
                    w_state_nxt    = S_SIZE;
                end
            end
            S_SIZE: begin
                if (w_xfer) begin
                    w_tx_nxt        = 1'b0;
                    w_remaining_nxt = r_len;
                    w_loaded_nxt    = 8'd0;
                    w_state_nxt     = (r_len == 8'd0) ? S_DONE : S_PAYLOAD;
                end
            end
            S_PAYLOAD: begin
                if (w_xfer) begin
                    w_remaining_nxt = r_remaining - 8'd1;
                end
                if (w_xfer && (r_remaining == 8'd1)) begin
                    w_tx_nxt    = 1'b0;
                    w_state_nxt = S_DONE;
                end else if (w_data_ready) begin
                    w_data_out_nxt = bus.i_data;
                    w_tx_nxt       = 1'b1;
                    w_loaded_nxt   = r_loaded + 8'd1;
                end else if (w_xfer) begin
                    w_tx_nxt = 1'b0;
                end
            end
            S_DONE: begin
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_tx_nxt    = 1'b0;
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state     <= S_IDLE;
            r_tx        <= 1'b0;
            r_data_out  <= '0;
            r_len       <= 8'd0;
            r_remaining <= 8'd0;
            r_loaded    <= 8'd0;
        end else begin
            r_state     <= w_state_nxt;
            r_tx        <= w_tx_nxt;
            r_data_out  <= w_data_out_nxt;
            r_len       <= w_len_nxt;
            r_remaining <= w_remaining_nxt;
            r_loaded    <= w_loaded_nxt;
        end
    end

    assign bus.o_tx         = r_tx;
    assign bus.o_data_out   = r_data_out;
    assign bus.o_data_ready = w_data_ready;
    assign bus.o_req_ready  = (r_state == S_IDLE);
    assign bus.o_busy       = (r_state != S_IDLE);
    assign bus.o_pkt_sent   = (r_state == S_DONE);

endmodule

`default_nettype wire
